pri_dec_acc: RTL and testbench

- Inverse companion of pri_enc: accepts a stream of binary indices over a valid/ready handshake and decodes each into a one-hot bit, OR-ing them into a bitmap.
- Emits the accumulated bitmap, in pri_enc input format with the same ACT polarity, when it becomes full or on flush.
- Used to rebuild request/free vectors from serialized indices, so pri_enc can re-scan them.

---
 rtl/pri_pkg.sv | 18 +
 rtl/pri_dec_cell.sv | 14 +
 rtl/pri_dec_acc.sv | 126 ++++++++++++
 tb/tb_pri_dec_acc.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pri_pkg.sv
// Shared types and helpers for the priority decoder/encoder family.
package pri_pkg;

  typedef enum logic [1:0] {
    PRI_DEC_IDLE = 2'd0,
    PRI_DEC_ACC  = 2'd1,
    PRI_DEC_HOLD = 2'd2
  } pri_dec_state_e;

  // One-hot of idx within a field of the given width; all zeros when idx is out of range.
  function automatic logic [63:0] onehot(input int unsigned idx, input int unsigned width);
    logic [63:0] res;
    res = '0;
    if (idx < width && idx < 64) res[idx[5:0]] = 1'b1;
    return res;
  endfunction

endpackage

// File: rtl/pri_dec_cell.sv
// Binary index to one-hot decoder with range check; indices >= OUT decode to zero.
module pri_dec_cell #(
  parameter int OUT = 8,
  parameter int IN  = $clog2(OUT)
) (
  input  logic [IN-1:0]  in,
  output logic [OUT-1:0] onehot,
  output logic           legal
);

  assign legal  = (32'(in) < OUT);
  assign onehot = OUT'(pri_pkg::onehot(32'(in), OUT));

endmodule

// File: rtl/pri_dec_acc.sv
// Accumulates decoded indices into a bitmap and emits it when full or on flush.
// Optional dup_err output enabled by defining PRI_DEC_DUP_ERR_EN.
//
// state         | meaning
// PRI_DEC_IDLE  | bitmap empty, accepting; flush ignored
// PRI_DEC_ACC   | bitmap non-empty, accepting; flush or full closes it
// PRI_DEC_HOLD  | bitmap presented on out, waiting for out_ready
module pri_dec_acc
  import pri_pkg::*;
#(
  parameter int OUT = 8,
  parameter int IN  = $clog2(OUT),
  parameter int CNT = $clog2(OUT + 1),
  parameter bit ACT = 1'b1
) (
  input  logic           clk,
  input  logic           reset_,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [IN-1:0]  in,
  input  logic           flush,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [OUT-1:0] out,
  output logic [CNT-1:0] out_cnt
`ifdef PRI_DEC_DUP_ERR_EN
  ,
  output logic           dup_err
`endif
);

  pri_dec_state_e state;
  logic [OUT-1:0] map;
  logic [CNT-1:0] cnt;

  logic [OUT-1:0] dec;
  logic           legal;
  logic           accept;
  logic           new_bit;
  logic [OUT-1:0] map_nxt;
  logic [CNT-1:0] cnt_nxt;
  logic           full_nxt;

  pri_dec_cell #(.OUT(OUT), .IN(IN)) u_cell (
    .in     (in),
    .onehot (dec),
    .legal  (legal)
  );

  assign accept   = in_valid && in_ready;
  // An illegal index decodes to zero, so it can never count as a new bit.
  assign new_bit  = |(dec & ~map);
  assign map_nxt  = map | dec;
  assign cnt_nxt  = cnt + CNT'(new_bit);
  assign full_nxt = (cnt_nxt == CNT'(OUT));

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state     <= PRI_DEC_IDLE;
      map       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        PRI_DEC_IDLE: begin
          if (accept && legal) begin
            map <= map_nxt;
            cnt <= cnt_nxt;
            if (full_nxt) begin
              state     <= PRI_DEC_HOLD;
              out_valid <= 1'b1;
              in_ready  <= 1'b0;
            end else begin
              state <= PRI_DEC_ACC;
            end
          end
        end
        PRI_DEC_ACC: begin
          if (accept) begin
            map <= map_nxt;
            cnt <= cnt_nxt;
          end
          // A same-cycle index is merged above before the bitmap closes.
          if (flush || (accept && full_nxt)) begin
            state     <= PRI_DEC_HOLD;
            out_valid <= 1'b1;
            in_ready  <= 1'b0;
          end
        end
        PRI_DEC_HOLD: begin
          if (out_ready) begin
            state     <= PRI_DEC_IDLE;
            map       <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= PRI_DEC_IDLE;
          map       <= '0;
          cnt       <= '0;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign out     = ACT ? map : ~map;
  assign out_cnt = cnt;

`ifdef PRI_DEC_DUP_ERR_EN
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      dup_err <= 1'b0;
    end else if (out_valid && out_ready) begin
      dup_err <= 1'b0;
    end else if (accept && !new_bit) begin
      dup_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pri_dec_acc.sv
// Directed bench for pri_dec_acc: two OUT=8 instances (ACT high/low) share stimulus,
// an OUT=6 instance covers out-of-range indices; a priority-encoder model checks round trips.
module tb_pri_dec_acc;

  logic       clk = 1'b0;
  logic       reset_;
  logic       in_valid, flush, out_ready;
  logic [2:0] in;

  logic       h_in_ready, h_out_valid;
  logic [7:0] h_out;
  logic [3:0] h_out_cnt;
  logic       l_in_ready, l_out_valid;
  logic [7:0] l_out;
  logic [3:0] l_out_cnt;

  logic       c_in_valid, c_flush, c_out_ready;
  logic [2:0] c_in;
  logic       c_in_ready, c_out_valid;
  logic [5:0] c_out;
  logic [2:0] c_out_cnt;

`ifdef PRI_DEC_DUP_ERR_EN
  logic h_dup, l_dup, c_dup;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pri_dec_acc #(.OUT(8), .ACT(1'b1)) u_hi (
    .clk(clk), .reset_(reset_), .in_valid(in_valid), .in_ready(h_in_ready), .in(in),
    .flush(flush), .out_valid(h_out_valid), .out_ready(out_ready), .out(h_out),
    .out_cnt(h_out_cnt)
`ifdef PRI_DEC_DUP_ERR_EN
    , .dup_err(h_dup)
`endif
  );

  pri_dec_acc #(.OUT(8), .ACT(1'b0)) u_lo (
    .clk(clk), .reset_(reset_), .in_valid(in_valid), .in_ready(l_in_ready), .in(in),
    .flush(flush), .out_valid(l_out_valid), .out_ready(out_ready), .out(l_out),
    .out_cnt(l_out_cnt)
`ifdef PRI_DEC_DUP_ERR_EN
    , .dup_err(l_dup)
`endif
  );

  pri_dec_acc #(.OUT(6), .ACT(1'b1)) u_six (
    .clk(clk), .reset_(reset_), .in_valid(c_in_valid), .in_ready(c_in_ready), .in(c_in),
    .flush(c_flush), .out_valid(c_out_valid), .out_ready(c_out_ready), .out(c_out),
    .out_cnt(c_out_cnt)
`ifdef PRI_DEC_DUP_ERR_EN
    , .dup_err(c_dup)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] idx, input logic fl);
    in_valid = 1'b1;
    in       = idx;
    flush    = fl;
    step();
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  // Reference pri_enc: index of the highest bit at the active level; valid driven at ACT level.
  function automatic logic [3:0] enc(input logic [7:0] v, input logic act);
    logic [2:0] idx;
    logic       vld;
    idx = '0;
    vld = ~act;
    for (int i = 0; i < 8; i++) begin
      if (v[i] == act) begin
        idx = 3'(i);
        vld = act;
      end
    end
    return {vld, idx};
  endfunction

  initial begin
    logic [7:0] pat;
    logic [2:0] hi_idx;

    reset_ = 1'b0;
    in_valid = 1'b0; in = '0; flush = 1'b0; out_ready = 1'b0;
    c_in_valid = 1'b0; c_in = '0; c_flush = 1'b0; c_out_ready = 1'b0;
    repeat (3) step();

    // Reset state
    chk("rst_lo_out", 32'(l_out), 32'hFF);
    chk("rst_lo_valid", 32'(l_out_valid), 32'd0);
    chk("rst_lo_ready", 32'(l_in_ready), 32'd1);
    chk("rst_lo_cnt", 32'(l_out_cnt), 32'd0);
    chk("rst_hi_out", 32'(h_out), 32'h00);
`ifdef PRI_DEC_DUP_ERR_EN
    chk("rst_dup", 32'(h_dup), 32'd0);
`endif
    reset_ = 1'b1;
    step();

    // Single index then flush
    send(3'd3, 1'b0);
    chk("single_no_valid", 32'(h_out_valid), 32'd0);
    do_flush();
    chk("single_valid", 32'(h_out_valid), 32'd1);
    chk("single_out", 32'(h_out), 32'h08);
    chk("single_cnt", 32'(h_out_cnt), 32'd1);
    chk("single_lo_out", 32'(l_out), 32'hF7);
    in_valid = 1'b1; in = 3'd5; flush = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("hold_out", 32'(h_out), 32'h08);
      chk("hold_cnt", 32'(h_out_cnt), 32'd1);
      chk("hold_ready", 32'(h_in_ready), 32'd0);
      chk("hold_valid", 32'(h_out_valid), 32'd1);
    end
    in_valid = 1'b0; flush = 1'b0;
    consume();
    chk("cons_valid", 32'(h_out_valid), 32'd0);
    chk("cons_ready", 32'(h_in_ready), 32'd1);
    chk("cons_out", 32'(h_out), 32'h00);
    chk("cons_cnt", 32'(h_out_cnt), 32'd0);

    // Auto-emit on full
    for (int i = 0; i < 7; i++) send(3'(i), 1'b0);
    chk("full_pre_valid", 32'(h_out_valid), 32'd0);
    chk("full_pre_cnt", 32'(h_out_cnt), 32'd7);
    send(3'd7, 1'b0);
    chk("full_valid", 32'(h_out_valid), 32'd1);
    chk("full_out", 32'(h_out), 32'hFF);
    chk("full_cnt", 32'(h_out_cnt), 32'd8);
    chk("full_lo_out", 32'(l_out), 32'h00);
    chk("full_lo_valid", 32'(l_out_valid), 32'd1);
    consume();

    // Duplicate plus merge with flush
    send(3'd5, 1'b0);
    send(3'd5, 1'b0);
    chk("dup_cnt", 32'(h_out_cnt), 32'd1);
    send(3'd2, 1'b1);
    chk("merge_valid", 32'(h_out_valid), 32'd1);
    chk("merge_out", 32'(h_out), 32'h24);
    chk("merge_cnt", 32'(h_out_cnt), 32'd2);
`ifdef PRI_DEC_DUP_ERR_EN
    chk("dup_err_set", 32'(h_dup), 32'd1);
    step();
    chk("dup_err_sticky", 32'(h_dup), 32'd1);
`endif
    consume();
`ifdef PRI_DEC_DUP_ERR_EN
    chk("dup_err_clr", 32'(h_dup), 32'd0);
`endif

    // Flush in IDLE is ignored
    flush = 1'b1;
    step();
    step();
    flush = 1'b0;
    chk("idle_flush_valid", 32'(h_out_valid), 32'd0);
    chk("idle_flush_ready", 32'(h_in_ready), 32'd1);
    step();
    chk("idle_flush_valid2", 32'(h_out_valid), 32'd0);

    // OUT=6: out-of-range index is accepted and dropped
    chk("six_ready", 32'(c_in_ready), 32'd1);
    c_in_valid = 1'b1; c_in = 3'd7;
    step();
    c_in_valid = 1'b0;
    chk("six_drop_out", 32'(c_out), 32'h00);
    chk("six_drop_cnt", 32'(c_out_cnt), 32'd0);
`ifdef PRI_DEC_DUP_ERR_EN
    chk("six_dup_err", 32'(c_dup), 32'd1);
`endif
    c_flush = 1'b1;
    step();
    c_flush = 1'b0;
    chk("six_still_idle", 32'(c_out_valid), 32'd0);
    c_in_valid = 1'b1; c_in = 3'd5;
    step();
    c_in_valid = 1'b0; c_flush = 1'b1;
    step();
    c_flush = 1'b0;
    chk("six_valid", 32'(c_out_valid), 32'd1);
    chk("six_out", 32'(c_out), 32'h20);
    c_out_ready = 1'b1;
    step();
    c_out_ready = 1'b0;
    chk("six_cons", 32'(c_out_valid), 32'd0);

    // Reset while accumulating
    send(3'd0, 1'b0);
    send(3'd4, 1'b0);
    chk("mid_map", 32'(h_out), 32'h11);
    chk("mid_cnt", 32'(h_out_cnt), 32'd2);
    #2 reset_ = 1'b0;
    #1;
    chk("mid_rst_out", 32'(h_out), 32'h00);
    chk("mid_rst_lo_out", 32'(l_out), 32'hFF);
    chk("mid_rst_cnt", 32'(h_out_cnt), 32'd0);
    chk("mid_rst_valid", 32'(h_out_valid), 32'd0);
    flush = 1'b1;
    step();
    reset_ = 1'b1;
    step();
    flush = 1'b0;
    chk("mid_after_valid", 32'(h_out_valid), 32'd0);
    chk("mid_after_out", 32'(h_out), 32'h00);

    // Round trip through a priority encoder
    for (int p = 1; p < 256; p++) begin
      pat = 8'(p);
      hi_idx = '0;
      for (int i = 7; i >= 0; i--) begin
        if (pat[i]) begin
          hi_idx = 3'(i);
          break;
        end
      end
      for (int i = 0; i < 8; i++) begin
        if (pat[i]) send(3'(i), 1'b0);
      end
      do_flush();
      chk("rt_valid", 32'(h_out_valid), 32'd1);
      chk("rt_out", 32'(h_out), 32'(pat));
      chk("rt_enc_hi", 32'(enc(h_out, 1'b1)), 32'({1'b1, hi_idx}));
      chk("rt_enc_lo", 32'(enc(l_out, 1'b0)), 32'({1'b0, hi_idx}));
      consume();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
